// File: rtl/mul_arbiter_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
// State encodings double as the cur_state debug view.
package mul_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 40;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_REQ0 = 2'b01;
  localparam logic [1:0] GNT_REQ1 = 2'b10;

endpackage

// File: rtl/mul_arbiter_rr_arb2.sv
// Two-way round-robin picker; the pointer remembers the last granted requester
// and only moves when the caller commits the grant via load.
module rr_arb2
  import mul_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       load,
  output logic [1:0] gnt_next,
  output logic       valid
);

  // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie.
  logic last_q, last_d;

  always_comb begin
    gnt_next = GNT_NONE;
    case (req)
      2'b01:   gnt_next = GNT_REQ0;
      2'b10:   gnt_next = GNT_REQ1;
      2'b11:   gnt_next = last_q ? GNT_REQ0 : GNT_REQ1;
      default: gnt_next = GNT_NONE;
    endcase
    valid  = |req;
    last_d = last_q;
    if (load && valid) begin
      last_d = gnt_next[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one shift-add multiplier between two requesters: round-robin pick,
// op_clear/op_start sequencing, result capture, and a timeout watchdog.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic [1:0]         gnt,
  output logic [1:0]         ack,
  output logic               err,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               busy,
  output logic [2:0]         cur_state,
  output logic               m_op_start,
  output logic               m_op_clear,
  output logic [WIDTH-1:0]   m_multiplier,
  output logic [WIDTH-1:0]   m_multiplicand,
  input  logic               m_op_done,
  input  logic [2*WIDTH-1:0] m_result
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WDW-1:0]     wdog_q, wdog_d;
  logic [1:0]         arb_gnt;
  logic               arb_valid, arb_load;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (reset),
    .req      (req),
    .load     (arb_load),
    .gnt_next (arb_gnt),
    .valid    (arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    res_d      = res_q;
    wdog_d     = wdog_q;
    arb_load   = 1'b0;
    ack        = GNT_NONE;
    err        = 1'b0;
    m_op_start = 1'b0;
    m_op_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          arb_load = 1'b1;
          gnt_d    = arb_gnt;
          opa_d    = arb_gnt[1] ? a1 : a0;
          opb_d    = arb_gnt[1] ? b1 : b0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        m_op_clear = 1'b1;
        wdog_d     = '0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        m_op_start = 1'b1;
        wdog_d     = wdog_q + 1'b1;
        // op_done takes priority over a watchdog expiry in the same cycle.
        if (m_op_done) begin
          res_d   = m_result;
          state_d = S_DONE;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          res_d   = '0;
          state_d = S_ABORT;
        end
      end
      S_DONE: begin
        ack        = gnt_q;
        m_op_clear = 1'b1;
        gnt_d      = GNT_NONE;
        state_d    = S_IDLE;
      end
      S_ABORT: begin
        ack        = gnt_q;
        err        = 1'b1;
        m_op_clear = 1'b1;
        gnt_d      = GNT_NONE;
        state_d    = S_IDLE;
      end
      default: begin
        gnt_d   = GNT_NONE;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= GNT_NONE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      wdog_q  <= wdog_d;
    end
  end

  assign gnt            = gnt_q;
  assign busy           = (state_q != S_IDLE);
  assign cur_state      = state_q;
  assign rsp_result     = res_q;
  assign m_multiplier   = opa_q;
  assign m_multiplicand = opb_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural multiplier whose latency,
// hang behaviour and result source can be changed per scenario.
module tb_mul_arbiter;

  localparam logic [63:0] STUB_RES = 64'h0123_4567_89AB_CDEF;

  logic        clk, reset;
  logic [1:0]  req;
  logic [31:0] a0, b0, a1, b1;
  logic [1:0]  gnt, ack;
  logic        err, busy;
  logic [63:0] rsp_result;
  logic [2:0]  cur_state;
  logic        m_op_start, m_op_clear;
  logic [31:0] m_multiplier, m_multiplicand;
  logic        m_op_done;
  logic [63:0] m_result;

  int vectors;
  int miscompares;

  int lat;
  bit never;
  bit stub;
  int mcnt;

  mul_arbiter #(.WIDTH(32), .TIMEOUT(40)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .a0             (a0),
    .b0             (b0),
    .a1             (a1),
    .b1             (b1),
    .gnt            (gnt),
    .ack            (ack),
    .err            (err),
    .rsp_result     (rsp_result),
    .busy           (busy),
    .cur_state      (cur_state),
    .m_op_start     (m_op_start),
    .m_op_clear     (m_op_clear),
    .m_multiplier   (m_multiplier),
    .m_multiplicand (m_multiplicand),
    .m_op_done      (m_op_done),
    .m_result       (m_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: op_done becomes visible after lat edges of op_start.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt      <= 0;
      m_op_done <= 1'b0;
      m_result  <= '0;
    end else if (m_op_clear) begin
      mcnt      <= 0;
      m_op_done <= 1'b0;
    end else if (m_op_start && !m_op_done) begin
      mcnt <= mcnt + 1;
      if (!never && (mcnt + 1 == lat)) begin
        m_op_done <= 1'b1;
        m_result  <= stub ? STUB_RES : 64'(m_multiplier) * 64'(m_multiplicand);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_ack(input int maxc, output int edges, output int runs, output bit seen);
    edges = 0;
    runs  = 0;
    seen  = 1'b0;
    while (edges < maxc && !seen) begin
      @(posedge clk);
      #1;
      edges++;
      if (ack !== 2'b00) seen = 1'b1;
      else if (cur_state === 3'd2) runs++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    @(posedge clk);
    #1;
    vectors++;
    if ({gnt, ack, err, busy, m_op_start, m_op_clear, cur_state} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got gnt=%b ack=%b err=%b busy=%b st=%b cl=%b cs=%0d, want all 0",
               gnt, ack, err, busy, m_op_start, m_op_clear, cur_state);
    end
    vectors++;
    if ({rsp_result, m_multiplier, m_multiplicand} !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_data: got res=%h mr=%h md=%h, want 0", rsp_result, m_multiplier, m_multiplicand);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || cur_state !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b cs=%0d, want 0/0", busy, cur_state);
    end
  endtask

  task automatic test_single();
    int e, r;
    bit s;
    lat = 34; never = 1'b0; stub = 1'b0;
    a0 = 32'd3; b0 = 32'd5; req = 2'b01;
    @(posedge clk);
    #1;
    vectors++;
    if (gnt !== 2'b01 || m_op_clear !== 1'b1 || m_op_start !== 1'b0 || cur_state !== 3'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_clear: got gnt=%b cl=%b st=%b cs=%0d busy=%b, want 01/1/0/1/1",
               gnt, m_op_clear, m_op_start, cur_state, busy);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (m_op_clear !== 1'b0 || m_op_start !== 1'b1 || cur_state !== 3'd2 ||
        m_multiplier !== 32'd3 || m_multiplicand !== 32'd5) begin
      miscompares++;
      $display("FAIL single_run: got cl=%b st=%b cs=%0d mr=%0d md=%0d, want 0/1/2/3/5",
               m_op_clear, m_op_start, cur_state, m_multiplier, m_multiplicand);
    end
    wait_ack(100, e, r, s);
    req = 2'b00;
    vectors++;
    if (!s || ack !== 2'b01 || err !== 1'b0 || rsp_result !== 64'd15 || m_op_clear !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ack: got seen=%b ack=%b err=%b res=%0d cl=%b, want 1/01/0/15/1",
               s, ack, err, rsp_result, m_op_clear);
    end
    vectors++;
    if (e + 2 != 37) begin
      miscompares++;
      $display("FAIL single_latency: got %0d edges, want 37", e + 2);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || ack !== 2'b00 || gnt !== 2'b00) begin
      miscompares++;
      $display("FAIL single_after: got busy=%b ack=%b gnt=%b, want 0/00/00", busy, ack, gnt);
    end
  endtask

  task automatic test_tie();
    int e, r;
    bit s;
    do_reset();
    lat = 34; never = 1'b0; stub = 1'b0;
    a0 = 32'd7; b0 = 32'd6; a1 = 32'hFFFF_FFFF; b1 = 32'd2;
    req = 2'b11;
    @(posedge clk);
    #1;
    vectors++;
    if (gnt !== 2'b01) begin
      miscompares++;
      $display("FAIL tie_first_gnt: got %b, want 01", gnt);
    end
    wait_ack(100, e, r, s);
    req = 2'b10;
    vectors++;
    if (!s || ack !== 2'b01 || err !== 1'b0 || rsp_result !== 64'd42) begin
      miscompares++;
      $display("FAIL tie_ack0: got seen=%b ack=%b err=%b res=%h, want 1/01/0/2a", s, ack, err, rsp_result);
    end
    @(posedge clk);
    #1;
    wait_ack(100, e, r, s);
    req = 2'b00;
    vectors++;
    if (!s || ack !== 2'b10 || err !== 1'b0 || rsp_result !== 64'h1_FFFF_FFFE) begin
      miscompares++;
      $display("FAIL tie_ack1: got seen=%b ack=%b err=%b res=%h, want 1/10/0/1fffffffe", s, ack, err, rsp_result);
    end
    @(posedge clk);
    #1;
    // A lone requester-0 operation leaves requester 0 as last granted.
    req = 2'b01;
    wait_ack(100, e, r, s);
    req = 2'b00;
    vectors++;
    if (!s || ack !== 2'b01 || rsp_result !== 64'd42) begin
      miscompares++;
      $display("FAIL tie_solo0: got seen=%b ack=%b res=%h, want 1/01/2a", s, ack, rsp_result);
    end
    @(posedge clk);
    #1;
    req = 2'b11;
    @(posedge clk);
    #1;
    vectors++;
    if (gnt !== 2'b10) begin
      miscompares++;
      $display("FAIL tie_alternate_gnt: got %b, want 10", gnt);
    end
    wait_ack(100, e, r, s);
    req = 2'b01;
    vectors++;
    if (!s || ack !== 2'b10 || rsp_result !== 64'h1_FFFF_FFFE) begin
      miscompares++;
      $display("FAIL tie_alternate_ack: got seen=%b ack=%b res=%h, want 1/10/1fffffffe", s, ack, rsp_result);
    end
    @(posedge clk);
    #1;
    wait_ack(100, e, r, s);
    req = 2'b00;
    vectors++;
    if (!s || ack !== 2'b01 || rsp_result !== 64'd42) begin
      miscompares++;
      $display("FAIL tie_alternate_ack0: got seen=%b ack=%b res=%h, want 1/01/2a", s, ack, rsp_result);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int e, r;
    bit s;
    lat = 34; never = 1'b0; stub = 1'b0;
    a0 = 32'd12; b0 = 32'd11; req = 2'b01;
    wait_ack(100, e, r, s);
    a0 = 32'd9; b0 = 32'd9;
    vectors++;
    if (!s || ack !== 2'b01 || rsp_result !== 64'd132) begin
      miscompares++;
      $display("FAIL b2b_first: got seen=%b ack=%b res=%0d, want 1/01/132", s, ack, rsp_result);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || cur_state !== 3'd0) begin
      miscompares++;
      $display("FAIL b2b_idle: got busy=%b cs=%0d, want 0/0", busy, cur_state);
    end
    wait_ack(100, e, r, s);
    req = 2'b00;
    vectors++;
    if (!s || ack !== 2'b01 || err !== 1'b0 || rsp_result !== 64'd81 || e != 37) begin
      miscompares++;
      $display("FAIL b2b_second: got seen=%b ack=%b err=%b res=%0d edges=%0d, want 1/01/0/81/37",
               s, ack, err, rsp_result, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    int e, r;
    bit s;
    lat = 34; never = 1'b1; stub = 1'b0;
    a0 = 32'd5; b0 = 32'd5; req = 2'b01;
    wait_ack(200, e, r, s);
    req = 2'b00;
    vectors++;
    if (!s || ack !== 2'b01 || err !== 1'b1 || rsp_result !== 64'd0 ||
        m_op_clear !== 1'b1 || cur_state !== 3'd4) begin
      miscompares++;
      $display("FAIL timeout_abort: got seen=%b ack=%b err=%b res=%h cl=%b cs=%0d, want 1/01/1/0/1/4",
               s, ack, err, rsp_result, m_op_clear, cur_state);
    end
    vectors++;
    if (r != 40) begin
      miscompares++;
      $display("FAIL timeout_run_cycles: got %0d, want 40", r);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || ack !== 2'b00 || err !== 1'b0 || m_op_clear !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_after: got busy=%b ack=%b err=%b cl=%b, want 0/00/0/0", busy, ack, err, m_op_clear);
    end
    never = 1'b0;
  endtask

  task automatic test_coincide();
    int e, r;
    bit s;
    lat = 39; never = 1'b0; stub = 1'b1;
    a0 = 32'd1; b0 = 32'd1; req = 2'b01;
    wait_ack(200, e, r, s);
    req = 2'b00;
    vectors++;
    if (!s || ack !== 2'b01 || err !== 1'b0 || rsp_result !== STUB_RES || cur_state !== 3'd3) begin
      miscompares++;
      $display("FAIL coincide_done: got seen=%b ack=%b err=%b res=%h cs=%0d, want 1/01/0/%h/3",
               s, ack, err, rsp_result, cur_state, STUB_RES);
    end
    vectors++;
    if (r != 40) begin
      miscompares++;
      $display("FAIL coincide_run_cycles: got %0d, want 40", r);
    end
    @(posedge clk);
    #1;
    stub = 1'b0;
    lat = 34;
  endtask

  task automatic test_mid_reset();
    int e, r, acks;
    bit s;
    lat = 34; never = 1'b0; stub = 1'b0;
    a0 = 32'd3; b0 = 32'd5; req = 2'b01;
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (cur_state !== 3'd2) begin
      miscompares++;
      $display("FAIL midrst_pre: got cs=%0d, want 2", cur_state);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (gnt !== 2'b00 || ack !== 2'b00 || busy !== 1'b0 || m_op_start !== 1'b0 || cur_state !== 3'd0) begin
      miscompares++;
      $display("FAIL midrst_async: got gnt=%b ack=%b busy=%b st=%b cs=%0d, want 00/00/0/0/0",
               gnt, ack, busy, m_op_start, cur_state);
    end
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    acks = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (ack !== 2'b00) acks++;
    end
    vectors++;
    if (acks != 0) begin
      miscompares++;
      $display("FAIL midrst_no_ack: got %0d ack cycles, want 0", acks);
    end
    a0 = 32'd2; b0 = 32'd2; req = 2'b01;
    wait_ack(100, e, r, s);
    req = 2'b00;
    vectors++;
    if (!s || ack !== 2'b01 || err !== 1'b0 || rsp_result !== 64'd4) begin
      miscompares++;
      $display("FAIL midrst_recover: got seen=%b ack=%b err=%b res=%0d, want 1/01/0/4", s, ack, err, rsp_result);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    lat = 34;
    never = 1'b0;
    stub = 1'b0;
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_timeout();
    test_coincide();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Sequences and shares the single 32x32 shift-add multiplier (`mul`) between two requesters, e.g. the CPU execute stage and the accelerator port.
- Picks a requester by round-robin and latches that requester's operands.
- Drives the multiplier's op_clear/op_start protocol, waits for op_done, captures the 64-bit product and returns it with a one-cycle ack.
- A watchdog aborts any operation the multiplier fails to complete.

Parameters:
- WIDTH, 32: operand width; the product is 2*WIDTH.
- TIMEOUT, 40: maximum number of RUN cycles before abort. Must exceed the multiplier latency (WIDTH+2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  per-requester request level; held high until that requester's ack.
- a0, b0  in  WIDTH each  requester 0 multiplier/multiplicand; stable while req[0]=1.
- a1, b1  in  WIDTH each  requester 1 multiplier/multiplicand; stable while req[1]=1.
- gnt  out  2  one-hot grant; high from CLEAR through DONE/ABORT.
- ack  out  2  one-cycle completion pulse to the granted requester.
- err  out  1  high together with ack when the operation was aborted by timeout.
- rsp_result  out  2*WIDTH  product; valid while ack!=0.
- busy  out  1  high whenever state != IDLE.
- cur_state  out  3  debug view of the FSM state.
- m_op_start  out  1  to mul.op_start.
- m_op_clear  out  1  to mul.op_clear.
- m_multiplier  out  WIDTH  to mul.multiplier.
- m_multiplicand  out  WIDTH  to mul.multiplicand.
- m_op_done  in  1  from mul.op_done.
- m_result  in  2*WIDTH  from mul.result.

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE; the round-robin pointer is set so requester 0 wins the first tie.
  - gnt, ack, err, busy, m_op_start and m_op_clear are 0; rsp_result, the operand registers and the watchdog counter are 0.
  - Reset in the middle of an operation abandons it silently, with no ack. The multiplier gets its own reset in parallel.
- State IDLE (0):
  - If req is nonzero, grant one requester: a single requester wins directly; with both requesting, the one not granted last wins.
  - Latch the winner's operands into the internal m_multiplier/m_multiplicand registers, set gnt and the pointer, and go to CLEAR.
  - The operand registers feed the mul ports and stay constant until the next IDLE grant.
- State CLEAR (1): m_op_clear=1 and m_op_start=0 for exactly one cycle; the watchdog is zeroed; go to RUN.
- State RUN (2):
  - m_op_start=1 and the watchdog increments every cycle.
  - If m_op_done=1: capture m_result into rsp_result, drop m_op_start on the next cycle, go to DONE.
  - Else if watchdog == TIMEOUT-1: rsp_result=0, go to ABORT.
  - If op_done and timeout coincide, op_done wins (DONE).
- State DONE (3):
  - ack[g]=1 and err=0, where g is the granted requester; m_op_clear=1 to return mul to idle.
  - Next state IDLE; gnt drops on leaving.
- State ABORT (4): ack[g]=1, err=1, rsp_result=0, m_op_clear=1; next state IDLE.
- Requester rule: req must deassert on the clock edge that samples ack.
  - A req still high in the following IDLE cycle counts as a new request; back-to-back operations are legal this way.
- Latency: req sampled in IDLE at cycle T; CLEAR at T+1; RUN from T+2.
  - ack comes one cycle after the cycle in which op_done is seen.
  - With mul latency L, ack occurs at T+2+L+1.
- A request arriving during busy waits; its operands must stay stable.
- No state or reset values beyond those listed; encodings 5-7 go to IDLE.
- Width rules: pure pass-through with no truncation; the full 2*WIDTH product is returned.

Decomposition:
- Package mul_arb_pkg holds:
  - state encodings S_IDLE=3'd0, S_CLEAR=3'd1, S_RUN=3'd2, S_DONE=3'd3, S_ABORT=3'd4;
  - the default TIMEOUT;
  - the one-hot grant constants.
- Sub-module rr_arb2: 2-way round-robin picker containing the last-grant pointer register. Inputs are req and a load strobe; outputs are a one-hot gnt_next and a valid flag.
- The top level holds the FSM, operand/result registers and watchdog.

Test Plan:
- Single request: req=01, a0=3, b0=5, bench drives the real mul → gnt=01, one CLEAR pulse, ack=01 with rsp_result=15 and err=0; busy=0 the cycle after ack.
- Tie and fairness: req=11 from reset, a0=7/b0=6, a1=0xFFFFFFFF/b1=2:
  - first ack=01 with result 42;
  - then ack=10 with result 0x1_FFFFFFFE;
  - a second simultaneous pair grants requester 1 first only if it was not the last granted; this check confirms alternation.
- Back-to-back: req[0] held high through ack with new operands 9x9 → second ack 81, no idle-cycle loss beyond the one IDLE cycle.
- Timeout: a stub mul never asserts op_done → ack pulse with err=1 and rsp_result=0 after exactly TIMEOUT RUN cycles; m_op_clear pulses in ABORT.
- Boundary coincidence: the stub asserts op_done exactly on watchdog=TIMEOUT-1 → DONE path, err=0, captured result returned.
- Mid-operation reset: assert reset during RUN → gnt, ack, busy and m_op_start are 0 immediately (asynchronously), no ack issued; a request after reset release completes 2x2=4.
